// File: rtl/push_pop_sequencer.sv
// push_pop_sequencer: walks a Thumb PUSH/POP register list one register per
// cycle, driving register-file selects, memory strobes/addresses and the final
// SP update. Issue and completion of consecutive beats overlap by one cycle.
// Optional build macro: STACK_LIMIT_CHECK_EN (rejects PUSHes below STACK_BASE).
module push_pop_sequencer #(
  parameter int          WORD_BYTES = 4,
  parameter logic [31:0] STACK_BASE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        is_pop_i,
  input  logic [7:0]  reg_list_i,
  input  logic        extra_i,
  input  logic        stall_i,
  input  logic [31:0] sp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [3:0]  rd_select_o,
  output logic [3:0]  wr_select_o,
  output logic        rf_write_en_o,
  output logic        pc_load_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        sp_write_en_o,
  output logic [31:0] sp_out_o,
  output logic        fault_o
);

  localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

`ifdef STACK_LIMIT_CHECK_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_DRAIN,
    S_SPUPD,
    S_FAULT
  } state_t;

  state_t      state_reg, state_next;
  logic [8:0]  mask_reg;        // beats still to issue; bit 8 is LR/PC
  logic        is_pop_reg;
  logic [31:0] addr_reg;        // address of the beat being issued
  logic [31:0] new_sp_reg;
  logic        sp_en_reg;       // 0 for an empty list: complete without SP write
  logic        pend_valid_reg;  // a beat issued last cycle awaits completion
  logic [3:0]  pend_idx_reg;
  logic [31:0] pend_addr_reg;

  logic        run;
  logic        in_xfer;
  logic        accept;
  logic [3:0]  n_cnt;
  logic [31:0] span;
  logic [31:0] push_base;
  logic        limit_hit;
  logic        fault_hit;
  logic [8:0]  cur_bit;
  logic [3:0]  cur_idx;
  logic [8:0]  mask_rest;

  assign run     = !stall_i;
  assign in_xfer = (state_reg == S_XFER);
  assign accept  = (state_reg == S_IDLE) && start_i && run;

  // Beat count and stack span of the incoming request.
  always_comb begin
    n_cnt = {3'd0, extra_i};
    for (int i = 0; i < 8; i++) begin
      n_cnt = n_cnt + {3'd0, reg_list_i[i]};
    end
    span      = STRIDE * {28'd0, n_cnt};
    push_base = sp_i - span;
    // A borrow out of the subtraction or a base below the floor both fault.
    limit_hit = (sp_i < span) || (push_base < STACK_BASE);
    fault_hit = LIMIT_EN && !is_pop_i && limit_hit;
  end

  // Pick the lowest remaining register; LR/PC (bit 8) therefore goes last.
  always_comb begin
    cur_bit = '0;
    cur_idx = '0;
    for (int i = 8; i >= 0; i--) begin
      if (mask_reg[i]) begin
        cur_bit    = '0;
        cur_bit[i] = 1'b1;
        cur_idx    = (i == 8) ? (is_pop_reg ? 4'd15 : 4'd14) : 4'(i);
      end
    end
    mask_rest = mask_reg & ~cur_bit;
  end

  // Next-state logic and output decode; every strobe is gated by stall.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (fault_hit)          state_next = S_FAULT;
          else if (n_cnt == 4'd0) state_next = S_SPUPD;
          else                    state_next = S_XFER;
        end
      end
      S_XFER:  if (run && mask_rest == 9'd0) state_next = S_DRAIN;
      S_DRAIN: if (run) state_next = S_SPUPD;
      S_SPUPD: if (run) state_next = S_IDLE;
      S_FAULT: if (run) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    busy_o        = (state_reg != S_IDLE);
    rd_select_o   = (in_xfer && !is_pop_reg) ? cur_idx : 4'd0;
    wr_select_o   = (pend_valid_reg && is_pop_reg) ? pend_idx_reg : 4'd0;
    mem_read_o    = in_xfer && is_pop_reg && run;
    mem_write_o   = pend_valid_reg && !is_pop_reg && run;
    rf_write_en_o = pend_valid_reg && is_pop_reg && (pend_idx_reg != 4'd15) && run;
    pc_load_o     = pend_valid_reg && is_pop_reg && (pend_idx_reg == 4'd15) && run;
    // POP issues reads and PUSH completes writes, so one address bus suffices.
    if (in_xfer && is_pop_reg)              mem_addr_o = addr_reg;
    else if (pend_valid_reg && !is_pop_reg) mem_addr_o = pend_addr_reg;
    else                                    mem_addr_o = 32'd0;
    done_o        = (state_reg == S_SPUPD) && run;
    sp_write_en_o = (state_reg == S_SPUPD) && sp_en_reg && run;
    sp_out_o      = (state_reg == S_SPUPD) ? new_sp_reg : 32'd0;
`ifdef STACK_LIMIT_CHECK_EN
    fault_o       = (state_reg == S_FAULT) && run;
`else
    fault_o       = 1'b0;
`endif
  end

  // State register plus request latch and beat pipeline; everything holds on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      mask_reg       <= '0;
      is_pop_reg     <= 1'b0;
      addr_reg       <= '0;
      new_sp_reg     <= '0;
      sp_en_reg      <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_idx_reg   <= '0;
      pend_addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mask_reg   <= {extra_i, reg_list_i};
        is_pop_reg <= is_pop_i;
        addr_reg   <= is_pop_i ? sp_i : push_base;
        new_sp_reg <= is_pop_i ? (sp_i + span) : push_base;
        sp_en_reg  <= (n_cnt != 4'd0);
      end
      if (run) begin
        pend_valid_reg <= in_xfer;
        if (in_xfer) begin
          pend_idx_reg  <= cur_idx;
          pend_addr_reg <= addr_reg;
          mask_reg      <= mask_rest;
          addr_reg      <= addr_reg + STRIDE;
        end
      end
    end
  end

endmodule

// File: tb/tb_push_pop_sequencer.sv
// Scoreboard bench for push_pop_sequencer: the driver predicts every strobe
// (cycle, select, address) from the list semantics and queues it; a negedge
// monitor pops and compares whenever the DUT raises a strobe.
module tb_push_pop_sequencer;
  logic        clk = 1'b0;
  logic        rst, start_i, is_pop_i, extra_i, stall_i;
  logic [7:0]  reg_list_i;
  logic [31:0] sp_i;
  logic        busy_o, done_o, rf_write_en_o, pc_load_o, mem_read_o, mem_write_o;
  logic        sp_write_en_o, fault_o;
  logic [3:0]  rd_select_o, wr_select_o;
  logic [31:0] mem_addr_o, sp_out_o;

  localparam logic [31:0] TB_STACK_BASE = 32'h0000_1F00;

  push_pop_sequencer #(.WORD_BYTES(4), .STACK_BASE(TB_STACK_BASE)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .is_pop_i(is_pop_i),
    .reg_list_i(reg_list_i), .extra_i(extra_i), .stall_i(stall_i), .sp_i(sp_i),
    .busy_o(busy_o), .done_o(done_o), .rd_select_o(rd_select_o),
    .wr_select_o(wr_select_o), .rf_write_en_o(rf_write_en_o), .pc_load_o(pc_load_o),
    .mem_addr_o(mem_addr_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .sp_write_en_o(sp_write_en_o), .sp_out_o(sp_out_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int busy_lo = 1, busy_hi = 0;

  typedef struct {
    int          c;
    logic [3:0]  sel;
    logic [31:0] addr;
  } ev_t;
  ev_t q_pw[$], q_pr[$], q_rf[$], q_done[$], q_fault[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=strobe expected=none cyc=%0d", name, cyc);
  endtask

  // Monitor: compare each observed strobe with the oldest prediction.
  logic [3:0] prev_rd = 4'd0;
  ev_t        e;
  always @(negedge clk) begin
    chk("busy", {31'd0, busy_o}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
    if (stall_i)
      chk("stall_gate", {25'd0, mem_read_o, mem_write_o, rf_write_en_o, pc_load_o,
                         sp_write_en_o, done_o, fault_o}, 32'd0);
    if (busy_o)
      chk("excl", {30'd0, mem_read_o & mem_write_o, rf_write_en_o & pc_load_o}, 32'd0);
    if (mem_write_o) begin
      if (q_pw.size() == 0) unexpected("mem_write");
      else begin
        e = q_pw.pop_front();
        chk("pw_cyc", cyc, e.c);
        chk("pw_addr", mem_addr_o, e.addr);
        chk("pw_rdsel", {28'd0, prev_rd}, {28'd0, e.sel});
      end
    end
    if (mem_read_o) begin
      if (q_pr.size() == 0) unexpected("mem_read");
      else begin
        e = q_pr.pop_front();
        chk("pr_cyc", cyc, e.c);
        chk("pr_addr", mem_addr_o, e.addr);
      end
    end
    if (rf_write_en_o || pc_load_o) begin
      if (q_rf.size() == 0) unexpected("rf_write");
      else begin
        e = q_rf.pop_front();
        chk("rf_cyc", cyc, e.c);
        chk("rf_sel", {28'd0, (pc_load_o ? 4'd15 : wr_select_o)}, {28'd0, e.sel});
      end
    end
    if (done_o) begin
      if (q_done.size() == 0) unexpected("done");
      else begin
        e = q_done.pop_front();
        chk("done_cyc", cyc, e.c);
        chk("sp_we", {31'd0, sp_write_en_o}, {31'd0, e.sel[0]});
        if (e.sel[0]) chk("sp_out", sp_out_o, e.addr);
      end
    end else if (sp_write_en_o) unexpected("sp_write");
    if (fault_o) begin
      if (q_fault.size() == 0) unexpected("fault");
      else begin
        e = q_fault.pop_front();
        chk("fault_cyc", cyc, e.c);
      end
    end
    if (!stall_i) prev_rd <= rd_select_o;
  end

  // Issue one request; stall_mask forces stalls at given cycle offsets after accept.
  task automatic run_op(input bit pop, input logic [7:0] list, input bit extra,
                        input logic [31:0] sp, input int stall_pct,
                        input int stall_mask, input int pre_stall);
    int n, need, a, k, i;
    logic [31:0] span, base, nsp;
    int u[$];
    bit pat[$];
    bit s, flt;
    logic [3:0] idx[$];
    n    = $countones(list) + int'(extra);
    span = 32'(4 * n);
    base = pop ? sp : sp - span;
    nsp  = pop ? sp + span : sp - span;
    flt  = 1'b0;
`ifdef STACK_LIMIT_CHECK_EN
    flt = !pop && ((sp < span) || (sp - span < TB_STACK_BASE));
`endif
    need = (flt || n == 0) ? 1 : n + 2;
    i = 0;
    while (u.size() < need) begin
      s = (i < 32 && stall_mask[i]) || ($urandom_range(99) < stall_pct);
      pat.push_back(s);
      if (!s) u.push_back(i);
      i++;
    end
    for (int r = 0; r < 8; r++) if (list[r]) idx.push_back(4'(r));
    if (extra) idx.push_back(pop ? 4'd15 : 4'd14);

    is_pop_i = pop; reg_list_i = list; extra_i = extra; sp_i = sp; start_i = 1'b1;
    stall_i = 1'b1;
    repeat (pre_stall) begin @(posedge clk); #1; end
    stall_i = 1'b0;
    @(posedge clk); #1;
    a = cyc;
    if (flt) q_fault.push_back('{a + u[0], 4'd0, 32'd0});
    else if (n == 0) q_done.push_back('{a + u[0], 4'd0, 32'd0});
    else begin
      for (k = 0; k < n; k++) begin
        if (pop) begin
          q_pr.push_back('{a + u[k], 4'd0, base + 32'(4 * k)});
          q_rf.push_back('{a + u[k + 1], idx[k], 32'd0});
        end else
          q_pw.push_back('{a + u[k + 1], idx[k], base + 32'(4 * k)});
      end
      q_done.push_back('{a + u[n + 1], 4'd1, nsp});
    end
    busy_lo = a;
    busy_hi = a + u[need - 1];
    for (int j = 0; j < pat.size(); j++) begin
      stall_i = pat[j];
      start_i = 1'($urandom_range(1));      // must be ignored while busy
      is_pop_i = 1'($urandom_range(1));
      reg_list_i = 8'($urandom);
      sp_i = $urandom;
      @(posedge clk); #1;
    end
    start_i = 1'b0; stall_i = 1'b0;
    repeat ($urandom_range(2)) begin @(posedge clk); #1; end
  endtask

  // POP of four registers, reset in its second cycle.
  task automatic reset_abort();
    int a;
    is_pop_i = 1'b1; reg_list_i = 8'h0F; extra_i = 1'b0; sp_i = 32'h3000;
    start_i = 1'b1; stall_i = 1'b0;
    @(posedge clk); #1;
    a = cyc;
    start_i = 1'b0;
    q_pr.push_back('{a, 4'd0, 32'h3000});
    q_pr.push_back('{a + 1, 4'd0, 32'h3004});
    q_rf.push_back('{a + 1, 4'd0, 32'd0});
    busy_lo = a; busy_hi = a + 1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ctl", {15'd0, busy_o, done_o, rd_select_o, wr_select_o, rf_write_en_o,
                      pc_load_o, mem_read_o, mem_write_o, sp_write_en_o, fault_o}, 32'd0);
    chk("abort_addr", mem_addr_o, 32'd0);
    chk("abort_sp", sp_out_o, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; is_pop_i = 1'b0; reg_list_i = 8'd0;
    extra_i = 1'b0; stall_i = 1'b0; sp_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {15'd0, busy_o, done_o, rd_select_o, wr_select_o, rf_write_en_o,
                      pc_load_o, mem_read_o, mem_write_o, sp_write_en_o, fault_o}, 32'd0);
    chk("reset_addr", mem_addr_o, 32'd0);
    chk("reset_sp", sp_out_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 8'b0000_0011, 1'b1, 32'h2000, 0, 0, 0);   // PUSH {r0,r1,LR}
    run_op(1'b1, 8'b1000_0100, 1'b1, 32'h1FF4, 0, 0, 0);   // POP {r2,r7,PC}
    run_op(1'b0, 8'd0, 1'b0, 32'h0500, 0, 0, 0);           // empty list
    run_op(1'b0, 8'b0001_1000, 1'b0, 32'h0100, 0, 32'b110, 0); // stall cycles 2-3
    run_op(1'b1, 8'hFF, 1'b1, 32'hFFFF_FFF0, 0, 0, 2);     // wrap, stalled accept
    reset_abort();
    run_op(1'b1, 8'b0000_0001, 1'b0, 32'h4000, 0, 0, 0);   // accepted after reset
    run_op(1'b0, 8'hFF, 1'b0, 32'h1F10, 0, 0, 0);          // below floor when checked
    run_op(1'b0, 8'hFF, 1'b0, 32'h1F20, 0, 0, 0);          // lands exactly on floor
    run_op(1'b0, 8'h01, 1'b1, 32'h0000_0004, 0, 0, 0);     // subtraction wraps

    for (int t = 0; t < 200; t++) begin
      logic [31:0] sp;
      sp = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
      run_op(1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)), sp,
             30, 0, $urandom_range(1));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queues_drained", 32'(q_pw.size() + q_pr.size() + q_rf.size()
                              + q_done.size() + q_fault.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
